var_state1: RTL
===============

Name: var_state1

Overview:
- Per-variable state cell at the bottom of one clause-array column; the counterpart of the literal cells in that column.
- Consumes the OR-combined implication/conflict value and implication level driven down the column.
- Holds the variable's assigned value, implied flag, decision level and reason flag, and broadcasts value/level back up to every literal cell of the column.
- Handles decide, imply, conflict detection, analysis marking, backtrack and load.

Parameters:
WIDTH_LVL, 16, width of decision-level fields

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
var_value_down_i  in  3  column bottom value; [2:1] 00 free, 01/10 polarity, 11 conflict; [0] implication request
var_lvl_down_i  in  WIDTH_LVL  level of the first implying clause
var_value_o  out  3  broadcast to literals; [2:1] value_r, [0] implied_r
var_lvl_o  out  WIDTH_LVL  broadcast level, lvl_r
apply_imply_i  in  1  imply phase strobe
apply_decide_i  in  1  decide this variable
decide_value_i  in  2  decided polarity (01 or 10)
cur_lvl_i  in  WIDTH_LVL  current decision level
apply_analyze_i  in  1  conflict-analysis strobe
apply_bkt_i  in  1  backtrack strobe
bkt_lvl_i  in  WIDTH_LVL  backtrack target level
wr_i  in  1  load state
value_i  in  2  load value
implied_i  in  1  load implied flag
lvl_i  in  WIDTH_LVL  load level
new_imp_o  out  1  one-cycle pulse: variable newly implied
conflict_o  out  1  variable in CONFLICT state
reason_o  out  1  variable marked by conflict clause during analysis
free_o  out  1  state FREE

Behaviour:
- State register: FREE, DECIDED, IMPLIED, CONFLICT. Reset: FREE; value_r=00, implied_r=0, lvl_r=0, reason_r=0, new_imp_o=0. All outputs therefore reset to 0, except free_o=1.
- Outputs are registered state. var_value_o={value_r,implied_r}, var_lvl_o=lvl_r, conflict_o=(state==CONFLICT), free_o=(state==FREE). new_imp_o is a registered pulse.
- Per-cycle priority: wr_i > apply_bkt_i > apply_decide_i > apply_imply_i > apply_analyze_i.
- wr_i:
  - Loads value_r/implied_r/lvl_r from value_i/implied_i/lvl_i; reason_r=0.
  - Next state: value_i==00 -> FREE; 11 -> CONFLICT; otherwise implied_i ? IMPLIED : DECIDED.
- apply_bkt_i:
  - If state!=FREE and (lvl_r > bkt_lvl_i or state==CONFLICT): go to FREE, clear value_r, implied_r, lvl_r and reason_r.
  - Otherwise only reason_r is cleared.
  - Equal level (lvl_r==bkt_lvl_i) is retained.
- apply_decide_i:
  - Honoured only in FREE: DECIDED, value_r=decide_value_i, implied_r=0, lvl_r=cur_lvl_i.
  - Ignored in other states.
  - decide_value_i of 00 or 11 is illegal; the cell ignores it and stays FREE.
- apply_imply_i:
  - In FREE with var_value_down_i[0]=1:
    - [2:1] in {01,10}: IMPLIED, value_r=[2:1], implied_r=1, lvl_r=var_lvl_down_i; new_imp_o=1 next cycle.
    - [2:1]==11 (opposing implications from two clauses): CONFLICT, value_r=11, implied_r=1, lvl_r=var_lvl_down_i; new_imp_o=0.
    - [2:1]==00: no change.
  - In any non-FREE state: no change.
- apply_analyze_i:
  - In DECIDED/IMPLIED/CONFLICT with var_value_down_i[2:1]==11 (literal cells drive 11 under conflict_c_drv): reason_r=1.
  - Sticky until bkt or wr.
- new_imp_o is high for exactly one cycle after the accepting edge, even if apply_imply_i stays high (the state is then no longer FREE).
- Async reset asserted mid-operation returns to the reset values immediately. The first edge after deassert obeys normal priority.

Test Plan:
- Reset then idle -> var_value_o=000, var_lvl_o=0, free_o=1, conflict_o=0, new_imp_o=0.
- FREE, apply_imply_i=1, var_value_down_i=101, var_lvl_down_i=5 -> next cycle var_value_o=101, var_lvl_o=5, new_imp_o=1 for one cycle only while imply is held 3 cycles.
- FREE, apply_decide_i=1 and apply_imply_i=1 same cycle, decide_value_i=01, cur_lvl_i=3, down=101 -> var_value_o=010, lvl 3, new_imp_o=0.
- FREE, apply_imply_i with down=111, lvl 7 -> conflict_o=1, var_value_o=111. Then apply_analyze_i with down=110 -> reason_o=1. Then apply_bkt_i, bkt_lvl_i=2 -> FREE, reason_o=0, var_value_o=000.
- DECIDED at lvl 4: apply_bkt_i bkt_lvl_i=4 -> retained. Then bkt_lvl_i=3 -> FREE.
- wr_i with value_i=10, implied_i=1, lvl_i=9 asserted together with apply_bkt_i -> load wins, IMPLIED, var_value_o=101, var_lvl_o=9. Assert rst mid-state -> outputs 0 immediately.

Source files
------------

// File: rtl/var_state1.sv
// Per-variable state cell at the bottom of a clause-array column: holds value, implied flag,
// decision level and reason mark, and broadcasts value/level back up to the literal cells.
module var_state1 #(
  parameter int WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           var_value_down_i,
  input  logic [WIDTH_LVL-1:0] var_lvl_down_i,
  output logic [2:0]           var_value_o,
  output logic [WIDTH_LVL-1:0] var_lvl_o,
  input  logic                 apply_imply_i,
  input  logic                 apply_decide_i,
  input  logic [1:0]           decide_value_i,
  input  logic [WIDTH_LVL-1:0] cur_lvl_i,
  input  logic                 apply_analyze_i,
  input  logic                 apply_bkt_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  input  logic                 wr_i,
  input  logic [1:0]           value_i,
  input  logic                 implied_i,
  input  logic [WIDTH_LVL-1:0] lvl_i,
  output logic                 new_imp_o,
  output logic                 conflict_o,
  output logic                 reason_o,
  output logic                 free_o
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_DECIDED  = 2'd1,
    ST_IMPLIED  = 2'd2,
    ST_CONFLICT = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [1:0]           value_r, value_s;
  logic                 implied_r, implied_s;
  logic [WIDTH_LVL-1:0] lvl_r, lvl_s;
  logic                 reason_r, reason_s;
  logic                 new_imp_r, new_imp_s;

  // Next-state logic: only the highest-priority asserted strobe acts in a given cycle.
  always_comb begin
    state_s   = state_r;
    value_s   = value_r;
    implied_s = implied_r;
    lvl_s     = lvl_r;
    reason_s  = reason_r;
    new_imp_s = 1'b0;
    if (wr_i) begin
      value_s   = value_i;
      implied_s = implied_i;
      lvl_s     = lvl_i;
      reason_s  = 1'b0;
      case (value_i)
        2'b00:   state_s = ST_FREE;
        2'b11:   state_s = ST_CONFLICT;
        default: state_s = implied_i ? ST_IMPLIED : ST_DECIDED;
      endcase
    end else if (apply_bkt_i) begin
      reason_s = 1'b0;
      // A conflicting variable is always undone; others only above the target level.
      if ((state_r != ST_FREE) && ((lvl_r > bkt_lvl_i) || (state_r == ST_CONFLICT))) begin
        state_s   = ST_FREE;
        value_s   = 2'b00;
        implied_s = 1'b0;
        lvl_s     = {WIDTH_LVL{1'b0}};
      end else begin
        state_s = state_r;
      end
    end else if (apply_decide_i) begin
      if ((state_r == ST_FREE) && ((decide_value_i == 2'b01) || (decide_value_i == 2'b10))) begin
        state_s   = ST_DECIDED;
        value_s   = decide_value_i;
        implied_s = 1'b0;
        lvl_s     = cur_lvl_i;
      end else begin
        state_s = state_r;
      end
    end else if (apply_imply_i) begin
      if ((state_r == ST_FREE) && var_value_down_i[0]) begin
        case (var_value_down_i[2:1])
          2'b01, 2'b10: begin
            state_s   = ST_IMPLIED;
            value_s   = var_value_down_i[2:1];
            implied_s = 1'b1;
            lvl_s     = var_lvl_down_i;
            new_imp_s = 1'b1;
          end
          2'b11: begin
            state_s   = ST_CONFLICT;
            value_s   = 2'b11;
            implied_s = 1'b1;
            lvl_s     = var_lvl_down_i;
          end
          default: state_s = state_r;
        endcase
      end else begin
        state_s = state_r;
      end
    end else if (apply_analyze_i) begin
      if ((state_r != ST_FREE) && (var_value_down_i[2:1] == 2'b11)) begin
        reason_s = 1'b1;
      end else begin
        reason_s = reason_r;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FREE;
      value_r   <= 2'b00;
      implied_r <= 1'b0;
      lvl_r     <= {WIDTH_LVL{1'b0}};
      reason_r  <= 1'b0;
      new_imp_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      value_r   <= value_s;
      implied_r <= implied_s;
      lvl_r     <= lvl_s;
      reason_r  <= reason_s;
      new_imp_r <= new_imp_s;
    end
  end

  assign var_value_o = {value_r, implied_r};
  assign var_lvl_o   = lvl_r;
  assign new_imp_o   = new_imp_r;
  assign conflict_o  = (state_r == ST_CONFLICT);
  assign reason_o    = reason_r;
  assign free_o      = (state_r == ST_FREE);

endmodule
